change_dispenser: RTL and testbench

Return-side counterpart of the coin-accepting vending logic: given a change amount in yuan, it pays it out as 50/20/10/5 coins through a req/ack handshake with the coin-ejector mechanism. It tracks per-denomination stock, inserts a mechanical settling gap between coins, and reports the remaining amount for the 7-segment display. On success or failure it issues a single done pulse.

---
 rtl/change_dispenser.sv | 194 +++++++++++++++++++
 tb/tb_change_dispenser.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Change payout engine: greedily ejects 50/20/10/5 coins through a req/ack handshake,
// tracking per-denomination stock, inter-coin settling gap and ejector timeout.
module change_dispenser #(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int INIT_CNT       = 8,
  parameter int CNT_W          = 4
) (
  input  logic       CLK100MHZ,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] amount,
  input  logic       refill,
  input  logic       coin_ack,
  output logic [3:0] coin_req,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] remaining,
  output logic [3:0] stock_empty
);

  localparam int TMR_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] TMO_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STOCK_INIT = CNT_W'(INIT_CNT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_REQ    = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  function automatic logic [7:0] coin_value(input logic [3:0] onehot);
    logic [7:0] val;
    case (onehot)
      4'b0001: val = 8'd5;
      4'b0010: val = 8'd10;
      4'b0100: val = 8'd20;
      4'b1000: val = 8'd50;
      default: val = 8'd0;
    endcase
    return val;
  endfunction

  state_t           r_state;
  logic [3:0]       r_coin_req;
  logic             r_busy;
  logic             r_done;
  logic             r_error;
  logic [7:0]       r_remaining;
  logic [TMR_W-1:0] r_tmr;
  logic [CNT_W-1:0] r_stock [4];
  logic [3:0]       r_stock_empty;

  logic             w_refill_take;
  logic             w_ack_take;
  logic [3:0]       w_avail;
  logic [3:0]       w_pick;
  logic             w_mod5_ok;
  logic [7:0]       w_coin_val;
  logic [CNT_W-1:0] w_stock_nxt [4];

  assign coin_req    = r_coin_req;
  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;
  assign remaining   = r_remaining;
  assign stock_empty = r_stock_empty;

  // Handshake/refill qualification and the greedy denomination choice
  always_comb begin
    w_refill_take = (r_state == S_IDLE) && refill;
    w_ack_take    = (r_state == S_REQ) && coin_ack && (r_coin_req != 4'b0000);
    w_mod5_ok     = ((r_remaining % 8'd5) == 8'd0);
    w_coin_val    = coin_value(r_coin_req);
    for (int i = 0; i < 4; i++) begin
      w_avail[i] = (r_stock[i] != {CNT_W{1'b0}});
    end
    if ((r_remaining >= 8'd50) && w_avail[3]) begin
      w_pick = 4'b1000;
    end else if ((r_remaining >= 8'd20) && w_avail[2]) begin
      w_pick = 4'b0100;
    end else if ((r_remaining >= 8'd10) && w_avail[1]) begin
      w_pick = 4'b0010;
    end else if ((r_remaining >= 8'd5) && w_avail[0]) begin
      w_pick = 4'b0001;
    end else begin
      w_pick = 4'b0000;
    end
  end

  // Next stock value: refill wins in IDLE, an accepted coin decrements its denomination
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (w_refill_take) begin
        w_stock_nxt[i] = STOCK_INIT;
      end else if (w_ack_take && r_coin_req[i]) begin
        w_stock_nxt[i] = r_stock[i] - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        w_stock_nxt[i] = r_stock[i];
      end
    end
  end

  // Stock counters and their registered empty flags
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_stock[i]       <= STOCK_INIT;
        r_stock_empty[i] <= (STOCK_INIT == {CNT_W{1'b0}});
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_stock[i]       <= w_stock_nxt[i];
        r_stock_empty[i] <= (w_stock_nxt[i] == {CNT_W{1'b0}});
      end
    end
  end

  // Payout sequencer with registered handshake and status outputs
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_coin_req  <= 4'b0000;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_remaining <= 8'd0;
      r_tmr       <= {TMR_W{1'b0}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_remaining <= amount;
            r_error     <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (r_remaining == 8'd0) begin
            r_error <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (!w_mod5_ok || (w_pick == 4'b0000)) begin
            // Unpayable amount or stock exhausted: remaining keeps what is still owed
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_coin_req <= w_pick;
            r_tmr      <= {TMR_W{1'b0}};
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (w_ack_take) begin
            r_coin_req  <= 4'b0000;
            r_remaining <= r_remaining - w_coin_val;
            r_tmr       <= {TMR_W{1'b0}};
            r_state     <= S_GAP;
          end else if (r_tmr == TMO_LAST) begin
            r_coin_req <= 4'b0000;
            r_error    <= 1'b1;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_tmr <= r_tmr + {{(TMR_W-1){1'b0}}, 1'b1};
          end
        end
        S_GAP: begin
          if (r_tmr == GAP_LAST) begin
            r_state <= S_SELECT;
          end else begin
            r_tmr <= r_tmr + {{(TMR_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          r_coin_req <= 4'b0000;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: a default instance and an INIT_CNT=2 instance
// share the stimulus through a select, with table-driven payouts plus hand sequences.
module tb_change_dispenser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, refill, coin_ack, sel;
  logic [7:0] amount;
  logic [3:0] req_a, req_b, emp_a, emp_b;
  logic       busy_a, busy_b, done_a, done_b, err_a, err_b;
  logic [7:0] rem_a, rem_b;

  logic [3:0] coin_req, stock_empty;
  logic       busy, done, error;
  logic [7:0] remaining;

  int checks = 0;
  int errors = 0;

  logic [3:0] coin_q [$];
  logic [7:0] rem_q  [$];
  int         gap_q  [$];
  int         hold_q [$];

  change_dispenser dut_a (
    .CLK100MHZ(clk), .rst_n(rst_n), .start(start & ~sel), .amount(amount),
    .refill(refill & ~sel), .coin_ack(coin_ack & ~sel), .coin_req(req_a),
    .busy(busy_a), .done(done_a), .error(err_a), .remaining(rem_a), .stock_empty(emp_a)
  );

  change_dispenser #(.INIT_CNT(2)) dut_b (
    .CLK100MHZ(clk), .rst_n(rst_n), .start(start & sel), .amount(amount),
    .refill(refill & sel), .coin_ack(coin_ack & sel), .coin_req(req_b),
    .busy(busy_b), .done(done_b), .error(err_b), .remaining(rem_b), .stock_empty(emp_b)
  );

  assign coin_req    = sel ? req_b  : req_a;
  assign busy        = sel ? busy_b : busy_a;
  assign done        = sel ? done_b : done_a;
  assign error       = sel ? err_b  : err_a;
  assign remaining   = sel ? rem_b  : rem_a;
  assign stock_empty = sel ? emp_b  : emp_a;

  function automatic logic [3:0] get_stock(input int i);
    if (sel) return dut_b.r_stock[i];
    else     return dut_a.r_stock[i];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_refill();
    @(posedge clk); #1; refill = 1'b1;
    @(posedge clk); #1; refill = 1'b0;
  endtask

  // Issues one start and plays the ejector; cyc counts edges after the start-sampling edge
  task automatic run_txn(input logic [7:0] amt, input int ack_dly, input logic do_ack,
                         output int done_cyc, output logic busy1, output logic busy_at_done);
    int cyc, hold, ack_edge;
    logic [3:0] prev;
    coin_q.delete(); rem_q.delete(); gap_q.delete(); hold_q.delete();
    done_cyc = 0; busy_at_done = 1'b1; hold = 0; ack_edge = -1; prev = 4'b0000;
    @(posedge clk); #1; start = 1'b1; amount = amt;
    @(posedge clk); #1; start = 1'b0; busy1 = busy; cyc = 1;
    while (done_cyc == 0 && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
      coin_ack = 1'b0;
      if (coin_req != 4'b0000 && prev == 4'b0000) begin
        coin_q.push_back(coin_req);
        rem_q.push_back(remaining);
        if (ack_edge >= 0) gap_q.push_back(cyc - ack_edge);
        hold = 0;
      end
      if (coin_req == 4'b0000 && prev != 4'b0000) hold_q.push_back(hold);
      if (coin_req != 4'b0000) begin
        hold++;
        if (do_ack && hold == ack_dly) begin
          coin_ack = 1'b1;
          ack_edge = cyc + 1;
        end
      end
      prev = coin_req;
      if (done) begin
        done_cyc     = cyc;
        busy_at_done = busy;
      end
    end
    coin_ack = 1'b0;
    check("done_seen", 32'(done_cyc != 0), 32'd1);
    @(posedge clk); #1;
    check("done_width", 32'(done), 32'd0);
  endtask

  typedef struct {
    logic        sel;
    logic [7:0]  amt;
    int          ack_dly;
    logic        do_ack;
    logic        refill_first;
    int          ncoins;
    logic [23:0] coins;
    logic [47:0] rems;
    logic        err;
    logic [7:0]  rem;
    logic [3:0]  empty;
    logic [15:0] stock;
    int          done_cyc;
    int          hold;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int dc, n, gap;
    logic b1, bd;
    logic [23:0] cw;
    logic [47:0] rw;
    logic [15:0] sw;

    tbl[0] = '{sel:1'b0, amt:8'd85,  ack_dly:3, do_ack:1'b1, refill_first:1'b0, ncoins:4,
               coins:24'h001248, rems:48'h0000_050F_2355, err:1'b0, rem:8'd0,
               empty:4'b0000, stock:16'h7777, done_cyc:0, hold:0};
    tbl[1] = '{sel:1'b0, amt:8'd23,  ack_dly:3, do_ack:1'b1, refill_first:1'b0, ncoins:0,
               coins:24'h0, rems:48'h0, err:1'b1, rem:8'd23,
               empty:4'b0000, stock:16'h7777, done_cyc:2, hold:0};
    tbl[2] = '{sel:1'b1, amt:8'd150, ack_dly:3, do_ack:1'b1, refill_first:1'b0, ncoins:5,
               coins:24'h024488, rems:48'h000A_1E32_6496, err:1'b0, rem:8'd0,
               empty:4'b1100, stock:16'h0012, done_cyc:0, hold:0};
    tbl[3] = '{sel:1'b1, amt:8'd50,  ack_dly:3, do_ack:1'b1, refill_first:1'b0, ncoins:3,
               coins:24'h000112, rems:48'h0000_0023_2832, err:1'b1, rem:8'd30,
               empty:4'b1111, stock:16'h0000, done_cyc:0, hold:0};
    tbl[4] = '{sel:1'b0, amt:8'd5,   ack_dly:0, do_ack:1'b0, refill_first:1'b1, ncoins:1,
               coins:24'h000001, rems:48'h0000_0000_0005, err:1'b1, rem:8'd5,
               empty:4'b0000, stock:16'h8888, done_cyc:1002, hold:1000};
    tbl[5] = '{sel:1'b0, amt:8'd0,   ack_dly:3, do_ack:1'b1, refill_first:1'b0, ncoins:0,
               coins:24'h0, rems:48'h0, err:1'b0, rem:8'd0,
               empty:4'b0000, stock:16'h8888, done_cyc:2, hold:0};

    rst_n = 1'b0; start = 1'b0; refill = 1'b0; coin_ack = 1'b0; amount = 8'd0; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_coin_req", 32'(req_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_error", 32'(err_a), 32'd0);
    check("rst_remaining", 32'(rem_a), 32'd0);
    check("rst_stock_empty", 32'({emp_a, emp_b}), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("rst_stock_a", 32'(dut_a.r_stock[i]), 32'd8);
      check("rst_stock_b", 32'(dut_b.r_stock[i]), 32'd2);
    end

    for (int v = 0; v < 6; v++) begin
      sel = tbl[v].sel;
      if (tbl[v].refill_first) do_refill();
      run_txn(tbl[v].amt, tbl[v].ack_dly, tbl[v].do_ack, dc, b1, bd);
      check($sformatf("v%0d_busy_start", v), 32'(b1), 32'd1);
      check($sformatf("v%0d_busy_at_done", v), 32'(bd), 32'd0);
      check($sformatf("v%0d_ncoins", v), 32'(coin_q.size()), 32'(tbl[v].ncoins));
      cw = tbl[v].coins;
      rw = tbl[v].rems;
      for (int k = 0; k < tbl[v].ncoins && k < coin_q.size(); k++) begin
        check($sformatf("v%0d_coin%0d", v, k), 32'(coin_q[k]), 32'(cw[4*k +: 4]));
        check($sformatf("v%0d_rem_at_coin%0d", v, k), 32'(rem_q[k]), 32'(rw[8*k +: 8]));
      end
      check($sformatf("v%0d_error", v), 32'(error), 32'(tbl[v].err));
      check($sformatf("v%0d_remaining", v), 32'(remaining), 32'(tbl[v].rem));
      check($sformatf("v%0d_stock_empty", v), 32'(stock_empty), 32'(tbl[v].empty));
      sw = tbl[v].stock;
      for (int i = 0; i < 4; i++)
        check($sformatf("v%0d_stock%0d", v, i), 32'(get_stock(i)), 32'(sw[4*i +: 4]));
      if (tbl[v].done_cyc != 0)
        check($sformatf("v%0d_done_cycle", v), 32'(dc), 32'(tbl[v].done_cyc));
      if (tbl[v].hold != 0) begin
        check($sformatf("v%0d_hold_seen", v), 32'(hold_q.size()), 32'd1);
        if (hold_q.size() > 0)
          check($sformatf("v%0d_req_hold", v), 32'(hold_q[0]), 32'(tbl[v].hold));
      end
      foreach (gap_q[g])
        check($sformatf("v%0d_gap%0d", v, g), 32'(gap_q[g]), 32'd17);
    end

    // 60-yuan payout: start/refill ignored while busy, then async reset mid-handshake
    sel = 1'b0;
    @(posedge clk); #1; start = 1'b1; amount = 8'd60;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    check("s5_first_coin", 32'(coin_req), 32'b1000);
    coin_ack = 1'b1;
    @(posedge clk); #1; coin_ack = 1'b0;
    check("s5_req_dropped", 32'(coin_req), 32'd0);
    check("s5_rem_after_ack", 32'(remaining), 32'd10);
    check("s5_stock50_after_ack", 32'(get_stock(3)), 32'd7);
    start = 1'b1; amount = 8'd5; refill = 1'b1;
    @(posedge clk); #1; start = 1'b0; refill = 1'b0;
    n = 1;
    check("s5_refill_ignored", 32'(get_stock(3)), 32'd7);
    check("s5_start_ignored", 32'(remaining), 32'd10);
    check("s5_busy", 32'(busy), 32'd1);
    gap = 0;
    while (gap == 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (coin_req != 4'b0000) gap = n;
    end
    check("s5_gap", 32'(gap), 32'd17);
    check("s5_second_coin", 32'(coin_req), 32'b0010);
    check("s5_rem_second", 32'(remaining), 32'd10);
    #2; rst_n = 1'b0;
    #1;
    check("s5_async_coin_req", 32'(coin_req), 32'd0);
    check("s5_async_busy", 32'(busy), 32'd0);
    check("s5_async_remaining", 32'(remaining), 32'd0);
    for (int i = 0; i < 4; i++)
      check($sformatf("s5_async_stock%0d", i), 32'(get_stock(i)), 32'd8);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    check("s5_post_reset_idle", 32'({coin_req, busy, done, error}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
